grant_finish_unit: RTL and testbench

GRANT_FINISH_UNIT -- requirements
Module: grant_finish_unit

---
 rtl/grant_finish_unit.sv | 168 ++++++++++++++++
 tb/tb_grant_finish_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_finish_unit.sv
// Purpose    : forwards grant beats to the client and queues one finish message
//              per completed grant that needs one.
// Latency    : grant path is combinational (zero cycles); a finish is visible on
//              io_fin_* the cycle after the last beat of its grant transfers.
// Backpressure: a grant beat that would enqueue a finish stalls (io_gin_ready=0,
//              io_gout_valid=0) while the finish queue is full; io_gout_ready is
//              passed straight back to io_gin_ready otherwise.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   io_gin_valid/ready/bits_*  - arbitrated grant beat in
//   io_gout_valid/ready/bits_* - grant beat out to the client (same fields)
//   io_fin_valid/ready/bits_*  - finish message {manager_xact_id, client_id}
//   io_beat_err                - sticky beat-order error
//
// Build option: define GRANT_BEAT_CHECK_EN to build the addr_beat order check
// that drives io_beat_err; otherwise io_beat_err is tied to 0.
// FINISH_DEPTH must be 2 or 4.

module grant_finish_unit #(
    parameter int FINISH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        io_gin_valid,
    output logic        io_gin_ready,
    input  logic [2:0]  io_gin_bits_addr_beat,
    input  logic [1:0]  io_gin_bits_client_xact_id,
    input  logic        io_gin_bits_manager_xact_id,
    input  logic        io_gin_bits_is_builtin_type,
    input  logic [3:0]  io_gin_bits_g_type,
    input  logic [63:0] io_gin_bits_data,
    input  logic        io_gin_bits_client_id,

    output logic        io_gout_valid,
    input  logic        io_gout_ready,
    output logic [2:0]  io_gout_bits_addr_beat,
    output logic [1:0]  io_gout_bits_client_xact_id,
    output logic        io_gout_bits_manager_xact_id,
    output logic        io_gout_bits_is_builtin_type,
    output logic [3:0]  io_gout_bits_g_type,
    output logic [63:0] io_gout_bits_data,
    output logic        io_gout_bits_client_id,

    output logic        io_fin_valid,
    input  logic        io_fin_ready,
    output logic        io_fin_bits_manager_xact_id,
    output logic        io_fin_bits_client_id,

    output logic        io_beat_err
);

    // Pointers are exactly log2(depth) bits so they wrap for free.
    localparam int PTR_W = (FINISH_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]       beat_cnt;
    logic             multi;
    logic             needs_fin;
    logic             last;
    logic             enq_fin;
    logic             full;
    logic             empty;
    logic             blocked;
    logic             xfer;
    logic             push;
    logic             pop;

    logic [1:0]       fin_mem [FINISH_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // ---------------------------------------------------------------
    // Grant path: pure wires, nothing stored.
    // ---------------------------------------------------------------
    assign io_gout_bits_addr_beat       = io_gin_bits_addr_beat;
    assign io_gout_bits_client_xact_id  = io_gin_bits_client_xact_id;
    assign io_gout_bits_manager_xact_id = io_gin_bits_manager_xact_id;
    assign io_gout_bits_is_builtin_type = io_gin_bits_is_builtin_type;
    assign io_gout_bits_g_type          = io_gin_bits_g_type;
    assign io_gout_bits_data            = io_gin_bits_data;
    assign io_gout_bits_client_id       = io_gin_bits_client_id;

    // Builtin g_type 5 and non-builtin g_type 0 carry 8 data beats.
    assign multi = io_gin_bits_is_builtin_type ? (io_gin_bits_g_type == 4'd5)
                                               : (io_gin_bits_g_type == 4'd0);

    assign needs_fin = !io_gin_bits_is_builtin_type ||
                       (io_gin_bits_g_type == 4'd4) ||
                       (io_gin_bits_g_type == 4'd5);

    assign last    = !multi || (beat_cnt == 3'd7);
    assign enq_fin = last && needs_fin;

    assign full  = (count == CNT_W'(FINISH_DEPTH));
    assign empty = (count == '0);

    // A full queue blocks the finishing beat even if the head pops this
    // cycle; this keeps ready off the fin_ready path.
    assign blocked = enq_fin && full;

    assign io_gout_valid = io_gin_valid  && !blocked;
    assign io_gin_ready  = io_gout_ready && !blocked;

    assign xfer = io_gin_valid && io_gin_ready;
    assign push = xfer && enq_fin && !reset;
    assign pop  = io_fin_valid && io_fin_ready;

    // ---------------------------------------------------------------
    // Beat counter and finish queue control.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (xfer && multi) begin
                beat_cnt <= beat_cnt + 3'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fin_mem[wr_ptr] <= {io_gin_bits_manager_xact_id, io_gin_bits_client_id};
        end
    end

    assign io_fin_valid = !empty;
    assign {io_fin_bits_manager_xact_id, io_fin_bits_client_id} =
        empty ? 2'b00 : fin_mem[rd_ptr];

    // ---------------------------------------------------------------
    // Optional beat-order check.
    // ---------------------------------------------------------------
`ifdef GRANT_BEAT_CHECK_EN
    logic beat_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_err_q <= 1'b0;
        end else if (xfer && multi && (io_gin_bits_addr_beat != beat_cnt)) begin
            beat_err_q <= 1'b1;
        end
    end

    assign io_beat_err = beat_err_q;
`else
    assign io_beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_finish_unit.sv
// Purpose : directed self-checking bench for grant_finish_unit (FINISH_DEPTH=2).
// Latency : inputs change 1 ns after a rising edge, outputs sampled 1 ns later.
// Backpressure: exercises full-queue stalls and gout_ready back-pressure.

module tb_grant_finish_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_gin_valid;
    logic        io_gin_ready;
    logic [2:0]  io_gin_bits_addr_beat;
    logic [1:0]  io_gin_bits_client_xact_id;
    logic        io_gin_bits_manager_xact_id;
    logic        io_gin_bits_is_builtin_type;
    logic [3:0]  io_gin_bits_g_type;
    logic [63:0] io_gin_bits_data;
    logic        io_gin_bits_client_id;
    logic        io_gout_valid;
    logic        io_gout_ready;
    logic [2:0]  io_gout_bits_addr_beat;
    logic [1:0]  io_gout_bits_client_xact_id;
    logic        io_gout_bits_manager_xact_id;
    logic        io_gout_bits_is_builtin_type;
    logic [3:0]  io_gout_bits_g_type;
    logic [63:0] io_gout_bits_data;
    logic        io_gout_bits_client_id;
    logic        io_fin_valid;
    logic        io_fin_ready;
    logic        io_fin_bits_manager_xact_id;
    logic        io_fin_bits_client_id;
    logic        io_beat_err;

    int total = 0;
    int bad   = 0;

`ifdef GRANT_BEAT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    grant_finish_unit #(.FINISH_DEPTH(2)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .io_gin_valid                 (io_gin_valid),
        .io_gin_ready                 (io_gin_ready),
        .io_gin_bits_addr_beat        (io_gin_bits_addr_beat),
        .io_gin_bits_client_xact_id   (io_gin_bits_client_xact_id),
        .io_gin_bits_manager_xact_id  (io_gin_bits_manager_xact_id),
        .io_gin_bits_is_builtin_type  (io_gin_bits_is_builtin_type),
        .io_gin_bits_g_type           (io_gin_bits_g_type),
        .io_gin_bits_data             (io_gin_bits_data),
        .io_gin_bits_client_id        (io_gin_bits_client_id),
        .io_gout_valid                (io_gout_valid),
        .io_gout_ready                (io_gout_ready),
        .io_gout_bits_addr_beat       (io_gout_bits_addr_beat),
        .io_gout_bits_client_xact_id  (io_gout_bits_client_xact_id),
        .io_gout_bits_manager_xact_id (io_gout_bits_manager_xact_id),
        .io_gout_bits_is_builtin_type (io_gout_bits_is_builtin_type),
        .io_gout_bits_g_type          (io_gout_bits_g_type),
        .io_gout_bits_data            (io_gout_bits_data),
        .io_gout_bits_client_id       (io_gout_bits_client_id),
        .io_fin_valid                 (io_fin_valid),
        .io_fin_ready                 (io_fin_ready),
        .io_fin_bits_manager_xact_id  (io_fin_bits_manager_xact_id),
        .io_fin_bits_client_id        (io_fin_bits_client_id),
        .io_beat_err                  (io_beat_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ab, input logic [1:0] cx, input logic mx,
                         input logic bi, input logic [3:0] gt, input logic [63:0] d,
                         input logic ci);
        io_gin_bits_addr_beat       = ab;
        io_gin_bits_client_xact_id  = cx;
        io_gin_bits_manager_xact_id = mx;
        io_gin_bits_is_builtin_type = bi;
        io_gin_bits_g_type          = gt;
        io_gin_bits_data            = d;
        io_gin_bits_client_id       = ci;
        io_gin_valid                = 1'b1;
    endtask

    // One beat presented for exactly one edge (caller ensures it is accepted).
    task automatic beat(input logic [2:0] ab, input logic [1:0] cx, input logic mx,
                        input logic bi, input logic [3:0] gt, input logic [63:0] d,
                        input logic ci);
        drive(ab, cx, mx, bi, gt, d, ci);
        step();
        io_gin_valid = 1'b0;
    endtask

    task automatic pop_one();
        io_fin_ready = 1'b1;
        step();
        io_fin_ready = 1'b0;
    endtask

    function automatic logic [1:0] fin_head();
        return {io_fin_bits_manager_xact_id, io_fin_bits_client_id};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        io_gout_ready = 1'b1;
        io_fin_ready  = 1'b0;
        drive(3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        io_gin_valid  = 1'b0;
        step();
        step();
        // Zero fields decode as beat 0 of a multi-beat grant: never blocked.
        check("rst_gin_ready_comb", io_gin_ready, 1'b1);
        reset = 1'b0;
        check("rst_fin_valid", io_fin_valid, 1'b0);
        check("rst_fin_bits", fin_head(), 2'b00);
        check("rst_beat_err", io_beat_err, 1'b0);

        // gout_ready low blocks gin_ready but not gout_valid.
        io_gout_ready = 1'b0;
        drive(3'd0, 2'd1, 1'b0, 1'b1, 4'd3, 64'h1111, 1'b0);
        #1;
        check("bp_gin_ready", io_gin_ready, 1'b0);
        check("bp_gout_valid", io_gout_valid, 1'b1);
        io_gin_valid  = 1'b0;
        io_gout_ready = 1'b1;

        // Single builtin g_type 3 beat: passthrough, no finish.
        drive(3'd5, 2'd2, 1'b1, 1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567, 1'b0);
        #1;
        check("t1_gout_valid", io_gout_valid, 1'b1);
        check("t1_gin_ready", io_gin_ready, 1'b1);
        check("t1_data", io_gout_bits_data, 64'hDEAD_BEEF_0123_4567);
        check("t1_addr_beat", io_gout_bits_addr_beat, 3'd5);
        check("t1_cxid", io_gout_bits_client_xact_id, 2'd2);
        check("t1_gtype", io_gout_bits_g_type, 4'd3);
        step();
        io_gin_valid = 1'b0;
        check("t1_no_fin", io_fin_valid, 1'b0);

        // 8-beat non-builtin grant; the finish appears only after beat 7.
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 2'd0, 1'b1, 1'b0, 4'd0, 64'(i), 1'b1);
            if (i == 7) begin
                #1;
                check("t2_last_gout_valid", io_gout_valid, 1'b1);
            end
            step();
            io_gin_valid = 1'b0;
            if (i == 6) check("t2_no_early_fin", io_fin_valid, 1'b0);
        end
        check("t2_fin_valid", io_fin_valid, 1'b1);
        check("t2_fin_bits", fin_head(), 2'b11);
        pop_one();
        check("t2_popped", io_fin_valid, 1'b0);
        check("t2_empty_bits", fin_head(), 2'b00);

        // Full queue stalls a finishing beat until a pop completes.
        beat(3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 64'd0, 1'b1);
        beat(3'd0, 2'd1, 1'b1, 1'b1, 4'd4, 64'd1, 1'b0);
        drive(3'd0, 2'd2, 1'b1, 1'b1, 4'd4, 64'd2, 1'b1);
        #1;
        check("t3_full_gin_ready", io_gin_ready, 1'b0);
        check("t3_full_gout_valid", io_gout_valid, 1'b0);
        check("t3_head_first", fin_head(), 2'b01);
        step();
        drive(3'd0, 2'd3, 1'b0, 1'b1, 4'd3, 64'd9, 1'b0);
        #1;
        check("t3_full_nofin_pass", io_gout_valid, 1'b1);
        step();
        drive(3'd0, 2'd2, 1'b1, 1'b1, 4'd4, 64'd2, 1'b1);
        io_fin_ready = 1'b1;
        #1;
        check("t3_full_pop_gin_ready", io_gin_ready, 1'b0);
        step();
        io_fin_ready = 1'b0;
        check("t3_after_pop_gin_ready", io_gin_ready, 1'b1);
        check("t3_after_pop_gout_valid", io_gout_valid, 1'b1);
        check("t3_head_second", fin_head(), 2'b10);
        step();
        io_gin_valid = 1'b0;
        check("t3_head_still_second", fin_head(), 2'b10);
        pop_one();
        check("t3_head_third", fin_head(), 2'b11);
        pop_one();
        check("t3_drained", io_fin_valid, 1'b0);

        // One entry queued, push and pop in the same cycle.
        beat(3'd0, 2'd0, 1'b1, 1'b1, 4'd4, 64'd0, 1'b0);
        check("t4_head_a", fin_head(), 2'b10);
        drive(3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 64'd0, 1'b1);
        io_fin_ready = 1'b1;
        step();
        io_gin_valid = 1'b0;
        io_fin_ready = 1'b0;
        check("t4_fin_valid", io_fin_valid, 1'b1);
        check("t4_head_b", fin_head(), 2'b01);
        pop_one();
        check("t4_count_one", io_fin_valid, 1'b0);

        // Multi-beat builtin g_type 5 with beats 0,1,3.
        beat(3'd0, 2'd0, 1'b0, 1'b1, 4'd5, 64'd0, 1'b0);
        beat(3'd1, 2'd0, 1'b0, 1'b1, 4'd5, 64'd1, 1'b0);
        check("t5_err_in_order", io_beat_err, 1'b0);
        beat(3'd3, 2'd0, 1'b0, 1'b1, 4'd5, 64'd3, 1'b0);
        check("t5_err_skip", io_beat_err, ERR_EXP);
        step();
        check("t5_err_sticky", io_beat_err, ERR_EXP);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_err_cleared", io_beat_err, 1'b0);

        // Reset part-way through an 8-beat grant with a finish queued.
        beat(3'd0, 2'd0, 1'b1, 1'b1, 4'd4, 64'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat(3'(i), 2'd1, 1'b0, 1'b0, 4'd0, 64'(i), 1'b0);
        end
        check("t6_queued", io_fin_valid, 1'b1);
        reset = 1'b1;
        drive(3'd5, 2'd1, 1'b0, 1'b0, 4'd0, 64'd5, 1'b0);
        #1;
        check("t6_rst_gin_ready", io_gin_ready, 1'b1);
        step();
        reset = 1'b0;
        io_gin_valid = 1'b0;
        check("t6_fin_valid", io_fin_valid, 1'b0);
        check("t6_fin_bits", fin_head(), 2'b00);
        for (int i = 0; i < 8; i++) begin
            beat(3'(i), 2'd3, 1'b0, 1'b0, 4'd0, 64'(i + 100), 1'b1);
            if (i == 2) check("t6_no_fin_b2", io_fin_valid, 1'b0);
            if (i == 6) check("t6_no_fin_b6", io_fin_valid, 1'b0);
        end
        check("t6_fin_valid_done", io_fin_valid, 1'b1);
        check("t6_fin_bits_done", fin_head(), 2'b01);
        check("t6_no_err", io_beat_err, 1'b0);
        pop_one();
        check("t6_drained", io_fin_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
